// File: rtl/ip_uart_tx.sv
// ip_uart_tx: byte-serial UART transmitter (8N1, LSB first) with a TX FIFO.
// Build option: define UART_TX_PARITY_EN for 8E1 (even parity bit after data).
//
// Ports:
//   n_reset   in   async active-low reset
//   clk       in   system clock, rising edge
//   send_data in 8 byte to queue, written when send_req && !send_busy
//   send_req  in   write request (may be held; one byte per accepting edge)
//   send_busy out  FIFO full (registered)
//   tx_empty  out  FIFO empty, FSM idle, line idle (registered)
//   uart_tx   out  serial line, idle high (registered)
module ip_uart_tx #(
    parameter int unsigned CLK_DIV         = 651,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic       n_reset,
    input  logic       clk,
    input  logic [7:0] send_data,
    input  logic       send_req,
    output logic       send_busy,
    output logic       tx_empty,
    output logic       uart_tx
);

    localparam int unsigned AW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [15:0]   BAUD_RLD = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          busy_q;
    logic          empty_q;

    // Serializer
    state_t        state_q;
    logic [15:0]   baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    logic          push;
    logic          pop;
    logic [7:0]    head;

    // busy_q mirrors count==DEPTH, so a push on a full FIFO is always
    // dropped, even when the FSM pops on the same edge.
    assign push = send_req && !busy_q;
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= send_data;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
            busy_q  <= (count_d == CNT_FULL);
            // Uses the current FSM state, so it rises only once the
            // registered line has finished the stop bit.
            empty_q <= !push && (count_q == '0) && (state_q == S_IDLE);
        end
    end

    // Line value is registered from the current state, so uart_tx
    // trails the state by one cycle and never glitches.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
`ifdef UART_TX_PARITY_EN
                        par_q   <= ^head;
`endif
                        baud_q  <= BAUD_RLD;
                        bit_q   <= 3'd0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (baud_q == 16'd0) begin
                        baud_q  <= BAUD_RLD;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                S_DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_q == 16'd0) begin
                        baud_q  <= BAUD_RLD;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx_q <= par_q;
                    if (baud_q == 16'd0) begin
                        baud_q  <= BAUD_RLD;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_q == 16'd0) begin
                        baud_q  <= BAUD_RLD;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign send_busy = busy_q;
    assign tx_empty  = empty_q;
    assign uart_tx   = tx_q;

endmodule

// File: tb/tb_ip_uart_tx.sv
// tb_ip_uart_tx: directed self-checking bench for ip_uart_tx.
// Uses CLK_DIV=4, 16-entry FIFO; follows UART_TX_PARITY_EN if defined.
module tb_ip_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int LOG2    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       n_reset;
    logic [7:0] send_data;
    logic       send_req;
    logic       send_busy;
    logic       tx_empty;
    logic       uart_tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] rxq[$];
    int         rx_start[$];
    int         rx_ferr = 0;

    logic       acc;
    int         acc_n;
    int         k0;
    int         n;
    logic [7:0] nxt;
    logic [7:0] hs_exp [12];
    string      hs_str;

    ip_uart_tx #(
        .CLK_DIV        (CLK_DIV),
        .FIFO_DEPTH_LOG2(LOG2)
    ) dut (
        .n_reset  (n_reset),
        .clk      (clk),
        .send_data(send_data),
        .send_req (send_req),
        .send_busy(send_busy),
        .tx_empty (tx_empty),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples mid-bit on falling clock edges.
    always begin : rx
        logic [7:0] b;
        int         st;
        @(negedge clk);
        if (n_reset === 1'b1 && uart_tx === 1'b0) begin
            st = cyc;
            repeat (CLK_DIV / 2) @(negedge clk);
            if (uart_tx !== 1'b0) rx_ferr++;
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                b[i] = uart_tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CLK_DIV) @(negedge clk);
            if (uart_tx !== ^b) rx_ferr++;
`endif
            repeat (CLK_DIV) @(negedge clk);
            if (uart_tx !== 1'b1) rx_ferr++;
            rxq.push_back(b);
            rx_start.push_back(st);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rxq.size()) return {24'h0, rxq[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gap_at(input int i);
        if (i < rx_start.size() && i > 0) return rx_start[i] - rx_start[i-1];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_empty(input string tag);
        int w;
        w = 0;
        while (tx_empty !== 1'b1 && w < 3000) begin
            step();
            w++;
        end
        chk(tag, {31'h0, tx_empty}, 32'h1);
        repeat (2) step();
    endtask

    // Req-until-accepted master: holds send_req until an edge with !busy.
    task automatic send_byte(input logic [7:0] b, input string tag);
        logic a;
        int   w;
        send_req  = 1'b1;
        send_data = b;
        w = 0;
        do begin
            a = !send_busy;
            step();
            w++;
        end while (!a && w < 500);
        send_req  = 1'b0;
        send_data = 8'hxx;
        chk(tag, {31'h0, a}, 32'h1);
    endtask

    task automatic send_frame(input logic [7:0] b, input string tag);
        logic [NBITS-1:0] exp;
        exp = '1;
        exp[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        exp[9] = ^b;
`endif
        rxq.delete();
        send_req  = 1'b1;
        send_data = b;
        step();
        send_req  = 1'b0;
        send_data = 8'hxx;
        chk($sformatf("%s_empty_k", tag), {31'h0, tx_empty}, 32'h0);
        step();
        chk($sformatf("%s_line_k1", tag), {31'h0, uart_tx}, 32'h1);
        for (int i = 0; i < NBITS; i++) begin
            for (int j = 0; j < CLK_DIV; j++) begin
                step();
                chk($sformatf("%s_bit%0d_%0d", tag, i, j),
                    {31'h0, uart_tx}, {31'h0, exp[i]});
            end
        end
        chk($sformatf("%s_empty_last", tag), {31'h0, tx_empty}, 32'h0);
        step();
        chk($sformatf("%s_empty_end", tag), {31'h0, tx_empty}, 32'h1);
        chk($sformatf("%s_line_end", tag), {31'h0, uart_tx}, 32'h1);
        repeat (2) step();
        chk($sformatf("%s_rxn", tag), rxq.size(), 1);
        chk($sformatf("%s_rxb", tag), rx_at(0), {24'h0, b});
        chk($sformatf("%s_ferr", tag), rx_ferr, 0);
    endtask

    initial begin
        hs_exp = '{8'h50, 8'h53, 8'h52, 8'h41, 8'h4D, 8'h20,
                   8'h54, 8'h45, 8'h53, 8'h54, 8'h0D, 8'h0A};
        hs_str = "PSRAM TEST\r\n";

        n_reset   = 1'b1;
        send_req  = 1'b0;
        send_data = 8'h00;
        #1 n_reset = 1'b0;
        #1;
        chk("rst_line", {31'h0, uart_tx}, 32'h1);
        chk("rst_busy", {31'h0, send_busy}, 32'h0);
        chk("rst_empty", {31'h0, tx_empty}, 32'h1);
        repeat (3) step();
        n_reset = 1'b1;
        repeat (6) step();
        chk("idle_line", {31'h0, uart_tx}, 32'h1);
        chk("idle_empty", {31'h0, tx_empty}, 32'h1);

        send_frame(8'h55, "f55");
        send_frame(8'hA3, "fA3");

        // Reset during a start bit with a second byte queued.
        send_req  = 1'b1;
        send_data = 8'hA3;
        step();
        send_data = 8'h5A;
        step();
        send_req  = 1'b0;
        step();
        chk("mrst_pre_line", {31'h0, uart_tx}, 32'h0);
        chk("mrst_pre_empty", {31'h0, tx_empty}, 32'h0);
        n_reset = 1'b0;
        #1;
        chk("mrst_line", {31'h0, uart_tx}, 32'h1);
        chk("mrst_busy", {31'h0, send_busy}, 32'h0);
        chk("mrst_empty", {31'h0, tx_empty}, 32'h1);
        repeat (2) step();
        n_reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            chk($sformatf("mrst_idle%0d", i), {31'h0, uart_tx}, 32'h1);
        end
        chk("mrst_empty_end", {31'h0, tx_empty}, 32'h1);
        rxq.delete();
        rx_start.delete();
        rx_ferr = 0;

        // FIFO full with a held request.
        acc_n     = 0;
        k0        = 0;
        nxt       = 8'h00;
        send_req  = 1'b1;
        send_data = nxt;
        n = 0;
        while (n < 40) begin
            acc = !send_busy;
            step();
            n++;
            if (acc) begin
                if (acc_n == 0) k0 = cyc;
                acc_n++;
                nxt++;
                send_data = nxt;
            end
            if (send_busy) break;
        end
        chk("full_acc", acc_n, 17);
        chk("full_rise", cyc - k0, 16);
        n = 0;
        while (n < 100) begin
            acc = !send_busy;
            step();
            n++;
            if (acc) acc_n++;
            if (!send_busy) break;
        end
        send_req  = 1'b0;
        send_data = 8'hxx;
        chk("full_free", cyc - k0, 42);
        chk("full_noacc", acc_n, 17);
        wait_empty("full_drain");
        chk("full_rxn", rxq.size(), 17);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("full_rx%0d", i), rx_at(i), i);
        end
        chk("full_ferr", rx_ferr, 0);

        // Sequencer handshake with back-to-back frames.
        rxq.delete();
        rx_start.delete();
        for (int i = 0; i < 12; i++) begin
            send_byte(hs_str[i], $sformatf("hs_acc%0d", i));
        end
        wait_empty("hs_drain");
        chk("hs_rxn", rxq.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("hs_rx%0d", i), rx_at(i), {24'h0, hs_exp[i]});
        end
        for (int i = 1; i < 12; i++) begin
            chk($sformatf("hs_gap%0d", i), gap_at(i), NBITS * CLK_DIV + 1);
        end
        chk("hs_ferr", rx_ferr, 0);

        // 40 bytes in bursts of 10 across pointer wrap.
        rxq.delete();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 10; j++) begin
                nxt = 8'((b * 10 + j) * 37 + 5);
                send_byte(nxt, $sformatf("wrap_acc%0d_%0d", b, j));
                chk($sformatf("wrap_busy%0d_%0d", b, j),
                    {31'h0, send_busy}, 32'h0);
            end
            wait_empty($sformatf("wrap_drain%0d", b));
        end
        chk("wrap_rxn", rxq.size(), 40);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wrap_rx%0d", i), rx_at(i), {24'h0, 8'(i * 37 + 5)});
        end
        chk("wrap_empty", {31'h0, tx_empty}, 32'h1);
        chk("wrap_ferr", rx_ferr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_uart_tx.md
Name: ip_uart_tx

Overview:
- Byte-serial UART transmitter with a small TX FIFO. It is the downstream consumer of the test/monitor sequencers' send_data / send_req / send_busy interface and drives the board's UART TX pin.
- It decouples sequencer progress from line rate, so several characters can be queued without stalling.
- Frame format is 8N1 by default, LSB first, with an optional even-parity bit.

Parameters:
- CLK_DIV, 651, clock cycles per UART bit (75 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO entries (default 16 entries).

Ports:
- n_reset  input  1  asynchronous active-low reset.
- clk  input  1  system clock, rising edge.
- send_data  input  8  byte to transmit; sampled when send_req=1 and send_busy=0.
- send_req  input  1  transmit request; may be held high across several cycles.
- send_busy  output  1  FIFO full; a request is not accepted while this is 1.
- tx_empty  output  1  FIFO empty, FSM in IDLE and line idle (all data flushed).
- uart_tx  output  1  serial line, idle high.

Behaviour:
- Clock and reset: one clock, clk. Reset is n_reset, asynchronous and active-low. Every flop clears immediately on n_reset=0, independent of clk.
- Reset values: uart_tx=1, send_busy=0, tx_empty=1, FIFO count=0, read and write pointers=0, FSM=IDLE, baud counter=0.
- Accept rule: a byte is written on any rising edge where send_req=1 and send_busy=0. One byte is written per such edge; a held request writes repeatedly. Upstream deasserts send_req on the cycle after it observes send_busy=0.
- send_busy is registered: it is 1 when count equals 2^FIFO_DEPTH_LOG2.
- Push while full is ignored, even if a pop occurs on the same edge. The FIFO is never overwritten.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointers are FIFO_DEPTH_LOG2 bits wide and wrap naturally modulo depth. count is FIFO_DEPTH_LOG2+1 bits.
- FSM states: IDLE, START, DATA, PARITY (only when the parity feature is compiled in), STOP.
- IDLE: uart_tx=1. If count≠0, pop the head into the shift register, load baud counter=CLK_DIV-1, set bit index=0 and go to START.
- Latency: a byte accepted at edge k into an empty FIFO with FSM IDLE is popped at edge k+1. uart_tx falls at edge k+2.
- START: uart_tx=0 for CLK_DIV cycles.
- DATA: uart_tx=shift[0] for CLK_DIV cycles per bit, then shift right. After bit index 7, go to STOP, or to PARITY if that feature is present.
- STOP: uart_tx=1 for CLK_DIV cycles, then go to IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames, so the stop bit is CLK_DIV+1 cycles.
- Baud counter: decrements each cycle; the state or bit advances when it reaches 0, then it reloads CLK_DIV-1. Frame length is 10×CLK_DIV cycles (11× with parity).
- uart_tx is driven from a flop, so it is glitch-free.
- tx_empty = (count==0) and (FSM==IDLE). It is registered and deasserts on the edge that accepts a byte.
- Reset mid-frame: the line returns to 1 immediately and queued bytes are discarded. No partial frame resumes after reset release.
- send_data is ignored whenever no write occurs. X on send_data while send_req=0 must not propagate.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. uart_tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles. The frame is 11 bits (8E1).
- Undefined: the PARITY state and its logic are absent. The frame is 10 bits (8N1).

Test Plan:
- Reset/idle (CLK_DIV=4): hold n_reset=0 mid-frame -> uart_tx=1, send_busy=0 and tx_empty=1 on the same cycle, with no clk edge needed. After release, the line stays 1 with no send_req.
- Single byte 0x55 (CLK_DIV=4): push at edge k -> uart_tx falls at k+2. Bit sequence 0,1,0,1,0,1,0,1,0 then stop 1, each held 4 clocks. tx_empty returns to 1 at k+42.
- Byte 0xA3 with UART_TX_PARITY_EN: bits LSB-first 1,1,0,0,0,1,0,1, then parity 0, then stop 1. Total frame 44 clocks. Without the macro, no parity bit and a 40-clock frame.
- FIFO full (depth 16, CLK_DIV=4): hold send_req=1 with incrementing data 0x00.. -> 17 bytes accepted, then send_busy=1. The next byte is accepted only after the 0x00 frame completes. The receiver model decodes 0x00..0x10 in order with no loss or duplication.
- Sequencer handshake: drive the "PSRAM TEST\r\n" sequence with a req-until-!busy master -> receiver gets exactly 50 53 52 41 4D 20 54 45 53 54 0D 0A. Back-to-back frames are separated by a single idle cycle.
- Pointer wrap: push and drain 40 bytes in bursts of 10 -> order preserved across pointer wrap. count never exceeds 16 and tx_empty=1 at the end.
